// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and registered one-hot grant.
// Optional forced release after MAX_HOLD cycles is built when GRANT_TIMEOUT_EN is defined.
module ring_arbiter #(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDXW-1:0] idx_q, idx_d;

`ifdef GRANT_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]   hold_q, hold_d;
  logic            timeout_q, timeout_d;
`endif

  logic [IDXW-1:0] ptr_idx;
  logic            ptr_ok;
  logic [2*N-1:0]  req_sh;
  logic [IDXW:0]   pick_sum;
  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  logic            release_evt;
  logic [N-1:0]    ptr_next;

  // Scan order starts at the pointer bit; the doubled vector handles wrap-around.
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = IDXW'(i);
    end
    ptr_ok     = $onehot(ptr_q);
    req_sh     = {req, req} >> ptr_idx;
    pick_sum   = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && req_sh[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, ptr_idx} + (IDXW+1)'(k);
        if (pick_sum >= (IDXW+1)'(N)) pick_sum = pick_sum - (IDXW+1)'(N);
        pick_idx   = pick_sum[IDXW-1:0];
      end
    end
  end

  assign release_evt = done | ~req[idx_q];
  assign ptr_next    = {grant_q[N-2:0], grant_q[N-1]};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_ok ? ptr_q : {{(N-1){1'b0}}, 1'b1};
`ifdef GRANT_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          state_d           = ST_GRANT;
`ifdef GRANT_TIMEOUT_EN
          hold_d            = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_evt) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
`ifdef GRANT_TIMEOUT_EN
          hold_d  = '0;
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          // Forced release; pointer advances exactly as for a normal release.
          grant_d   = '0;
          ptr_d     = ptr_next;
          state_d   = ST_IDLE;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d  = hold_q + HW'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= {{(N-1){1'b0}}, 1'b1};
      grant_q <= '0;
      idx_q   <= '0;
`ifdef GRANT_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
`ifdef GRANT_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = (state_q == ST_GRANT);
`ifdef GRANT_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed-vector bench for ring_arbiter (N=4); expected values are hand-computed.
// Timeout checks follow GRANT_TIMEOUT_EN as the design does.
module tb_ring_arbiter;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic         done  = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         timeout;

  int n_vec = 0;
  int n_err = 0;

  ring_arbiter #(.N(N), .IDXW(2), .MAX_HOLD(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    if (b) chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  logic [3:0] seq [5];

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    @(negedge clock);
    do_reset();
    chk_out("rst", 4'b0000, 2'd0, 1'b0);
    chk("rst.idx", 32'(grant_idx), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);

    // 1: basic grant, release, turnaround, next grant
    req = 4'b0101;
    cyc();
    chk_out("t1.g0", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk_out("t1.idle", 4'b0000, 2'd0, 1'b0);
    cyc();
    chk_out("t1.g2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    cyc();
    chk_out("t1.rel", 4'b0000, 2'd0, 1'b0);

    // 2: full rotation with one idle cycle between grants
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out($sformatf("t2.g%0d", i), seq[i], 2'(i % 4), 1'b1);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk_out($sformatf("t2.gap%0d", i), 4'b0000, 2'd0, 1'b0);
    end
    req = 4'b0000;
    cyc();

    // 3: release of bit 3 wraps pointer to bit 0; scan passes empty bit 0
    do_reset();
    req = 4'b1000;
    cyc();
    chk_out("t3.g3", 4'b1000, 2'd3, 1'b1);
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 4'b1010;
    chk_out("t3.rel", 4'b0000, 2'd0, 1'b0);
    cyc();
    chk_out("t3.g1", 4'b0010, 2'd1, 1'b1);

    // 4: owner withdraws; pointer moves to bit 2, scan wraps to bit 0
    req = 4'b0000;
    cyc();
    chk_out("t4.drop", 4'b0000, 2'd0, 1'b0);
    req = 4'b0011;
    cyc();
    chk_out("t4.g0", 4'b0001, 2'd0, 1'b1);
    req = 4'b1111;
    cyc();
    chk_out("t4.hold", 4'b0001, 2'd0, 1'b1);
    req  = 4'b0000;
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk_out("t4.both", 4'b0000, 2'd0, 1'b0);
    req = 4'b0011;
    cyc();
    chk_out("t4.ptr1", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    cyc();

    // 5: hold limit
    do_reset();
    req = 4'b0001;
`ifdef GRANT_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_out($sformatf("t5.h%0d", i), 4'b0001, 2'd0, 1'b1);
      chk($sformatf("t5.to%0d", i), 32'(timeout), 32'd0);
    end
    cyc();
    chk_out("t5.force", 4'b0000, 2'd0, 1'b0);
    chk("t5.pulse", 32'(timeout), 32'd1);
    cyc();
    chk("t5.pulse_end", 32'(timeout), 32'd0);
    chk_out("t5.regrant", 4'b0001, 2'd0, 1'b1);
`else
    for (int i = 0; i < 22; i++) begin
      cyc();
      chk_out($sformatf("t5.h%0d", i), 4'b0001, 2'd0, 1'b1);
      chk($sformatf("t5.to%0d", i), 32'(timeout), 32'd0);
    end
`endif
    req = 4'b0000;
    cyc();

    // 6: reset mid-grant aborts and restores pointer to bit 0
    do_reset();
    req = 4'b0010;
    cyc();
    chk_out("t6.g1", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 4'b0100;
    cyc();
    chk_out("t6.g2", 4'b0100, 2'd2, 1'b1);
    reset = 1'b1;
    req   = 4'b0110;
    cyc();
    reset = 1'b0;
    chk_out("t6.rst", 4'b0000, 2'd0, 1'b0);
    chk("t6.rst_idx", 32'(grant_idx), 32'd0);
    chk("t6.rst_to", 32'(timeout), 32'd0);
    cyc();
    chk_out("t6.ptr0", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    cyc();
    req = 4'b0100;
    cyc();
    chk_out("t6.g2b", 4'b0100, 2'd2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
